// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and config address map for the multi-channel PWM
package pwm_pkg;
    localparam int CNT_W_DEF  = 8;
    localparam int NUM_CH_DEF = 3;

    // The period register sits just above the last duty register
    function automatic int PERIOD_ADDR(input int num_ch);
        return num_ch;
    endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: double-buffered duty register, comparator and registered output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic             load,
    input  logic             we,
    input  logic [CNT_W-1:0] data,
    input  logic             inv,
    output logic             pwm
);
    logic [CNT_W-1:0] duty_sh, duty_act, duty_nxt;

    assign duty_nxt = we ? data : duty_sh;

    // Shadow always tracks writes; active only follows on load; output idles at polarity level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= inv;
        end else begin
            duty_sh <= duty_nxt;
            if (load)
                duty_act <= duty_nxt;
            pwm <= en ? ((cnt < duty_act) ^ inv) : inv;
        end
    end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared period counter driving NUM_CH glitch-free PWM channels
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                NUM_CH         = NUM_CH_DEF,
    parameter int                CNT_W          = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = CNT_W'(255),
    parameter logic [NUM_CH-1:0] INVERT         = '0,
    localparam int               AW             = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [CNT_W-1:0]  cfg_data,
    input  logic              cfg_commit,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic              upd_pending
);
    localparam logic [AW-1:0] P_ADDR = AW'(PERIOD_ADDR(NUM_CH));

    logic [CNT_W-1:0] cnt, period_sh, period_act, period_nxt;
    logic             pending, wrap, load;

    // Transfers only at a period boundary or while idle, so the counter can never be stranded
    assign wrap       = (cnt == period_act);
    assign load       = (pending || cfg_commit) && (wrap || !en);
    assign period_nxt = (cfg_we && cfg_addr == P_ADDR) ? cfg_data : period_sh;
    assign upd_pending = pending;

    // Counter, period double buffer, commit tracking and period marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            period_sh    <= DEFAULT_PERIOD;
            period_act   <= DEFAULT_PERIOD;
            pending      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= (!en || wrap) ? '0 : cnt + CNT_W'(1);
            period_sh    <= period_nxt;
            if (load)
                period_act <= period_nxt;
            pending      <= (pending || cfg_commit) && !load;
            period_start <= en && (cnt == '0);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .cnt   (cnt),
            .load  (load),
            .we    (cfg_we && cfg_addr == AW'(i)),
            .data  (cfg_data),
            .inv   (INVERT[i]),
            .pwm   (pwm_out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed stimulus against a cycle model for normal and inverted instances
module tb_pwm_multi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       cfg_commit = 1'b0;
    logic [2:0] pwm_out, pwm_inv;
    logic       ps, ps_i, pend, pend_i;

    int compared = 0;
    int mismatched = 0;

    pwm_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_PERIOD(8'd255), .INVERT(3'b000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .pwm_out(pwm_out),
        .period_start(ps), .upd_pending(pend)
    );

    pwm_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_PERIOD(8'd255), .INVERT(3'b101)) dut_inv (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .pwm_out(pwm_inv),
        .period_start(ps_i), .upd_pending(pend_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position within the period, buffered configuration, pending commit
    int         m_pos, m_per, m_per_sh, m_pend, m_old;
    int         m_duty[3], m_duty_sh[3];
    bit         m_xfer;
    logic [2:0] e_pwm;
    logic       e_ps, e_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_per = 255; m_per_sh = 255; m_pend = 0;
            for (int i = 0; i < 3; i++) begin m_duty[i] = 0; m_duty_sh[i] = 0; end
            e_pwm = '0; e_ps = 1'b0; e_pend = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) e_pwm[i] = en && (m_pos < m_duty[i]);
            e_ps = en && (m_pos == 0);
            if (cfg_we) begin
                if (cfg_addr < 3) m_duty_sh[cfg_addr] = int'(cfg_data);
                else m_per_sh = int'(cfg_data);
            end
            m_old  = m_per;
            m_xfer = (m_pend != 0 || cfg_commit) && (m_pos == m_old || !en);
            if (m_xfer) begin
                m_per  = m_per_sh;
                m_duty = m_duty_sh;
            end
            m_pend = ((m_pend != 0 || cfg_commit) && !m_xfer) ? 1 : 0;
            m_pos  = en ? (m_pos + 1) % (m_old + 1) : 0;
            e_pend = m_pend[0];
        end
    end

    // Every cycle: both instances against the model
    always @(negedge clk) begin
        chk("pwm_out", int'(pwm_out), int'(e_pwm));
        chk("pwm_inv", int'(pwm_inv), int'(e_pwm ^ 3'b101));
        chk("period_start", int'(ps), int'(e_ps));
        chk("period_start_inv", int'(ps_i), int'(e_ps));
        chk("upd_pending", int'(pend), int'(e_pend));
        chk("upd_pending_inv", int'(pend_i), int'(e_pend));
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1 cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    task automatic commit();
        @(posedge clk); #1 cfg_commit = 1'b1;
        @(posedge clk); #1 cfg_commit = 1'b0;
    endtask

    task automatic wait_ps(input int lim);
        int k = 0;
        @(negedge clk);
        while (!ps && k < lim) begin @(negedge clk); k++; end
        chk("wait_period_start", int'(ps), 1);
    endtask

    task automatic wait_nopend(input int lim);
        int k = 0;
        @(negedge clk);
        while (pend && k < lim) begin @(negedge clk); k++; end
        chk("wait_pending_clear", int'(pend), 0);
    endtask

    task automatic count_win(input int n, output int ps_n, output int h0, output int h1,
                             output int h2, output int pn);
        ps_n = 0; h0 = 0; h1 = 0; h2 = 0; pn = 0;
        repeat (n) begin
            ps_n += int'(ps); h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]); pn += int'(pend);
            @(negedge clk);
        end
    endtask

    int n_ps, h0, h1, h2, n_pend;

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_pwm_inv", int'(pwm_inv), 5);
        chk("reset_ps", int'(ps), 0);
        chk("reset_pend", int'(pend), 0);
        @(posedge clk); #1 rst_n = 1'b1; en = 1'b1;

        // Idle defaults: no output, marker every 256 cycles
        @(negedge clk);
        count_win(512, n_ps, h0, h1, h2, n_pend);
        chk("t1_ps_count", n_ps, 2);
        chk("t1_high_total", h0 + h1 + h2, 0);

        // Three duties on the default period
        wr(0, 64); wr(1, 128); wr(2, 255); commit();
        wait_nopend(600);
        wait_ps(600);
        chk("t2_rise_aligned", int'(pwm_out[0]), 1);
        count_win(256, n_ps, h0, h1, h2, n_pend);
        chk("t2_h0", h0, 64);
        chk("t2_h1", h1, 128);
        chk("t2_h2", h2, 255);
        chk("t2_ps", n_ps, 1);

        // Short period, duty above period then zero duty
        wr(3, 9); wr(0, 10); commit();
        wait_nopend(600);
        wait_ps(600);
        count_win(20, n_ps, h0, h1, h2, n_pend);
        chk("t3_ps", n_ps, 2);
        chk("t3_h0_full", h0, 20);
        wr(0, 0); commit();
        wait_nopend(50);
        wait_ps(50);
        count_win(20, n_ps, h0, h1, h2, n_pend);
        chk("t3_h0_zero", h0, 0);
        chk("t3_ps2", n_ps, 2);

        // Commit at cnt=100: pending through cnt=255 only
        wr(3, 255); wr(0, 32); commit();
        wait_nopend(50);
        wr(0, 200);
        wait_ps(600);
        repeat (99) @(posedge clk);
        #1 cfg_commit = 1'b1;
        @(posedge clk); #1 cfg_commit = 1'b0;
        @(negedge clk);
        count_win(300, n_ps, h0, h1, h2, n_pend);
        chk("t4_pend_cycles", n_pend, 155);
        wait_ps(300);
        count_win(256, n_ps, h0, h1, h2, n_pend);
        chk("t4_h0", h0, 200);

        // Write and commit in the wrap cycle itself
        wait_ps(300);
        repeat (254) @(posedge clk);
        #1 cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd17; cfg_commit = 1'b1;
        @(posedge clk); #1 cfg_we = 1'b0; cfg_commit = 1'b0;
        @(negedge clk);
        chk("t5_ps_next", int'(ps), 0);
        @(negedge clk);
        chk("t5_ps_now", int'(ps), 1);
        count_win(256, n_ps, h0, h1, h2, n_pend);
        chk("t5_h1", h1, 17);
        chk("t5_no_pend", n_pend, 0);

        // Async reset at cnt=50
        wait_ps(300);
        repeat (49) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_pwm", int'(pwm_out), 0);
        chk("t6_rst_pwm_inv", int'(pwm_inv), 5);
        chk("t6_rst_ps", int'(ps), 0);
        chk("t6_rst_pend", int'(pend), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_restart_ps", int'(ps), 1);

        // Idle: commit applies immediately, first period after enable is complete
        @(posedge clk); #1 en = 1'b0;
        wr(0, 128); commit();
        @(negedge clk);
        chk("t7_idle_inv", int'(pwm_inv), 5);
        chk("t7_idle_ps", int'(ps), 0);
        chk("t7_idle_pend", int'(pend), 0);
        @(posedge clk); #1 en = 1'b1;
        wait_ps(10);
        count_win(256, n_ps, h0, h1, h2, n_pend);
        chk("t7_h0", h0, 128);
        chk("t7_h2", h2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
